// File: rtl/ir_transmitter_mod.sv
// Pulse-distance IR frame transmitter: sync burst/silence, per-bit burst plus 0/1 silence,
// stop burst, optional repeat frames with inter-frame gap, carrier modulation and abort.
module ir_transmitter_mod #(
    parameter int SBD            = 900_000,
    parameter int SSD            = 450_000,
    parameter int BBD            = 60_000,
    parameter int BSD0           = 60_000,
    parameter int BSD1           = 160_000,
    parameter int STOP_BD        = 60_000,
    parameter int GAP_D          = 4_000_000,
    parameter int MODULATE       = 1,
    parameter int CARRIER_PERIOD = 2500,
    parameter int CARRIER_HIGH   = 833,
    parameter int MAX_BITS       = 32,
    parameter int MSB_FIRST      = 1,
    parameter int REPEAT_W       = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            valid_in,
    input  logic [MAX_BITS-1:0]             data_in,
    input  logic [$clog2(MAX_BITS+1)-1:0]   len_in,
    input  logic [REPEAT_W-1:0]             repeat_in,
    input  logic                            abort_in,
    output logic                            ready_out,
    output logic                            busy_out,
    output logic                            done_out,
    output logic                            envelope_out,
    output logic                            signal_out
);

    localparam int LW = $clog2(MAX_BITS + 1);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BITS);
    localparam logic [31:0]   CC_LAST = 32'(CARRIER_PERIOD - 1);
    localparam logic [31:0]   CC_HIGH = 32'(CARRIER_HIGH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC_B = 3'd1,
        S_SYNC_S = 3'd2,
        S_BIT_B  = 3'd3,
        S_BIT_S  = 3'd4,
        S_STOP_B = 3'd5,
        S_GAP    = 3'd6
    } state_t;

    state_t                r_state;
    logic [31:0]           r_phase;
    logic [31:0]           r_cc;
    logic [MAX_BITS-1:0]   r_data;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_cnt;
    logic [REPEAT_W-1:0]   r_rep;

    state_t                w_next_state;
    logic                  w_done_next;
    logic                  w_enter;
    logic                  w_burst_next;
    logic                  w_sig_next;
    logic [31:0]           w_cc_next;
    logic [31:0]           w_phase_next;
    logic [31:0]           w_dur;
    logic                  w_phase_end;
    logic [LW-1:0]         w_bit_idx;
    logic [MAX_BITS-1:0]   w_shifted;
    logic                  w_cur_bit;
    logic                  w_last_bit;

    // Bits are counted in transmit order; map the count onto a payload index.
    assign w_bit_idx  = (MSB_FIRST != 0) ? (r_len - LW'(1) - r_cnt) : r_cnt;
    assign w_shifted  = r_data >> w_bit_idx;
    assign w_cur_bit  = w_shifted[0];
    assign w_last_bit = ((r_cnt + LW'(1)) == r_len);

    // Duration of the state currently occupied.
    always_comb begin
        w_dur = 32'd1;
        case (r_state)
            S_SYNC_B: w_dur = 32'(SBD);
            S_SYNC_S: w_dur = 32'(SSD);
            S_BIT_B:  w_dur = 32'(BBD);
            S_BIT_S:  w_dur = w_cur_bit ? 32'(BSD1) : 32'(BSD0);
            S_STOP_B: w_dur = 32'(STOP_BD);
            S_GAP:    w_dur = 32'(GAP_D);
            default:  w_dur = 32'd1;
        endcase
    end

    assign w_phase_end = (r_phase == (w_dur - 32'd1));

    // Next-state selection, including abort and frame repetition.
    always_comb begin
        w_next_state = r_state;
        w_done_next  = 1'b0;
        if (r_state == S_IDLE) begin
            if (valid_in && !abort_in) begin
                w_next_state = S_SYNC_B;
            end else begin
                w_next_state = S_IDLE;
            end
        end else if (abort_in) begin
            w_next_state = S_IDLE;
        end else if (w_phase_end) begin
            case (r_state)
                S_SYNC_B: w_next_state = S_SYNC_S;
                S_SYNC_S: w_next_state = (r_len == {LW{1'b0}}) ? S_STOP_B : S_BIT_B;
                S_BIT_B:  w_next_state = S_BIT_S;
                S_BIT_S:  w_next_state = w_last_bit ? S_STOP_B : S_BIT_B;
                S_STOP_B: begin
                    if (r_rep != {REPEAT_W{1'b0}}) begin
                        w_next_state = S_GAP;
                    end else begin
                        w_next_state = S_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
                S_GAP:    w_next_state = S_SYNC_B;
                default:  w_next_state = S_IDLE;
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // Phase and carrier counters restart on every state entry.
    always_comb begin
        w_enter      = (w_next_state != r_state);
        w_burst_next = (w_next_state == S_SYNC_B) || (w_next_state == S_BIT_B) ||
                       (w_next_state == S_STOP_B);
        if (w_enter || (w_next_state == S_IDLE)) begin
            w_phase_next = 32'd0;
        end else begin
            w_phase_next = r_phase + 32'd1;
        end
        if (!w_burst_next || w_enter) begin
            w_cc_next = 32'd0;
        end else if (r_cc == CC_LAST) begin
            w_cc_next = 32'd0;
        end else begin
            w_cc_next = r_cc + 32'd1;
        end
        w_sig_next = w_burst_next && ((MODULATE == 0) || (w_cc_next < CC_HIGH));
    end

    // State, counters, latched frame and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state      <= S_IDLE;
            r_phase      <= 32'd0;
            r_cc         <= 32'd0;
            r_data       <= {MAX_BITS{1'b0}};
            r_len        <= {LW{1'b0}};
            r_cnt        <= {LW{1'b0}};
            r_rep        <= {REPEAT_W{1'b0}};
            ready_out    <= 1'b1;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
            envelope_out <= 1'b0;
            signal_out   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_phase      <= w_phase_next;
            r_cc         <= w_cc_next;
            ready_out    <= (w_next_state == S_IDLE);
            busy_out     <= (w_next_state != S_IDLE);
            done_out     <= w_done_next;
            envelope_out <= w_burst_next;
            signal_out   <= w_sig_next;
            if ((r_state == S_IDLE) && valid_in && !abort_in) begin
                r_data <= data_in;
                r_len  <= (len_in > MAX_LEN) ? MAX_LEN : len_in;
                r_rep  <= repeat_in;
            end
            if ((r_state == S_STOP_B) && (w_next_state == S_GAP)) begin
                r_rep <= r_rep - REPEAT_W'(1);
            end
            if (w_enter && (w_next_state == S_SYNC_B)) begin
                r_cnt <= {LW{1'b0}};
            end else if (w_enter && (r_state == S_BIT_S)) begin
                r_cnt <= r_cnt + LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ir_transmitter_mod.sv
// Scoreboard bench: stimulus pushes the expected per-cycle output trace of each accepted
// frame request; a negedge monitor pops one entry per cycle and compares.
module tb_ir_transmitter_mod;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       valid_in;
    logic [7:0] data_in;
    logic [3:0] len_in;
    logic [3:0] repeat_in;
    logic       abort_in;
    logic       ready_out, busy_out, done_out, envelope_out, signal_out;

    always #5 clk_in = ~clk_in;

    ir_transmitter_mod #(
        .SBD(8), .SSD(4), .BBD(2), .BSD0(2), .BSD1(4), .STOP_BD(2), .GAP_D(6),
        .MODULATE(1), .CARRIER_PERIOD(4), .CARRIER_HIGH(2), .MAX_BITS(8),
        .MSB_FIRST(1), .REPEAT_W(4)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .data_in(data_in),
        .len_in(len_in), .repeat_in(repeat_in), .abort_in(abort_in),
        .ready_out(ready_out), .busy_out(busy_out), .done_out(done_out),
        .envelope_out(envelope_out), .signal_out(signal_out)
    );

    typedef struct packed {
        logic ready;
        logic done;
        logic env;
        logic sig;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    // Expected waveform of one burst or silence segment of the given length.
    task automatic push_seg(input logic lvl, input int dur);
        exp_t e;
        for (int i = 0; i < dur; i++) begin
            e.ready = 1'b0;
            e.done  = 1'b0;
            e.env   = lvl;
            e.sig   = lvl && ((i % 4) < 2);
            q.push_back(e);
        end
    endtask

    // Whole transaction: (rep+1) frames, gaps between, then one done/idle cycle.
    task automatic push_txn(input logic [7:0] d, input logic [3:0] len, input logic [3:0] rep);
        exp_t e;
        int   n;
        n = (len > 4'd8) ? 8 : int'(len);
        for (int f = 0; f <= int'(rep); f++) begin
            if (f > 0) push_seg(1'b0, 6);
            push_seg(1'b1, 8);
            push_seg(1'b0, 4);
            for (int i = 0; i < n; i++) begin
                push_seg(1'b1, 2);
                push_seg(1'b0, d[n-1-i] ? 4 : 2);
            end
            push_seg(1'b1, 2);
        end
        e.ready = 1'b1;
        e.done  = 1'b1;
        e.env   = 1'b0;
        e.sig   = 1'b0;
        q.push_back(e);
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        exp_t a;
        if (mon_en) begin
            if (q.size() > 0) begin
                e = q.pop_front();
            end else begin
                e.ready = 1'b1; e.done = 1'b0; e.env = 1'b0; e.sig = 1'b0;
            end
            a.ready = ready_out; a.done = done_out; a.env = envelope_out; a.sig = signal_out;
            checks++;
            if (a !== e || busy_out !== ~e.ready) begin
                errors++;
                $display("FAIL trace t=%0t actual rdy/done/env/sig=%b busy=%b required %b busy=%b",
                         $time, a, busy_out, e, ~e.ready);
            end
        end
    end

    // One-cycle request; accepted only if the DUT is idle at the sampling edge.
    task automatic send(input logic [7:0] d, input logic [3:0] len, input logic [3:0] rep,
                        input logic ab);
        logic acc;
        @(posedge clk_in); #2;
        acc = rst_n_in && !ab && (q.size() == 0 || (q.size() == 1 && q[0].ready));
        valid_in = 1'b1; data_in = d; len_in = len; repeat_in = rep; abort_in = ab;
        @(posedge clk_in); #2;
        valid_in = 1'b0; abort_in = 1'b0;
        data_in = 8'($urandom); len_in = 4'($urandom); repeat_in = 4'($urandom);
        if (acc) push_txn(d, len, rep);
    endtask

    task automatic do_abort();
        @(posedge clk_in); #2;
        abort_in = 1'b1;
        @(posedge clk_in); #2;
        abort_in = 1'b0;
        q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk_in); #2;
        rst_n_in = 1'b0;
        valid_in = 1'b1;
        @(posedge clk_in); #2;
        q.delete();
        repeat (2) @(posedge clk_in);
        #2;
        rst_n_in = 1'b1;
        valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 2000) begin
            @(posedge clk_in);
            n++;
        end
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain timeout actual %0d entries left required 0", q.size());
            q.delete();
        end
        repeat (2) @(posedge clk_in);
    endtask

    initial begin
        int sel;
        rst_n_in = 1'b0; valid_in = 1'b0; abort_in = 1'b0;
        data_in = 8'd0; len_in = 4'd0; repeat_in = 4'd0;
        @(posedge clk_in); #2;
        mon_en = 1'b1;
        repeat (2) @(posedge clk_in);
        #2;
        rst_n_in = 1'b1;

        send(8'b0000_0101, 4'd3, 4'd0, 1'b0);
        wait_drain();
        send(8'h01, 4'd1, 4'd2, 1'b0);
        wait_drain();
        send(8'h00, 4'd0, 4'd0, 1'b0);
        repeat (3) @(posedge clk_in);
        send(8'hFF, 4'd2, 4'd0, 1'b0);
        wait_drain();
        send(8'hA5, 4'd15, 4'd0, 1'b0);
        repeat (5) @(posedge clk_in);
        send(8'h3C, 4'd4, 4'd1, 1'b0);
        wait_drain();
        send(8'hFF, 4'd8, 4'd0, 1'b0);
        repeat (9) @(posedge clk_in);
        do_abort();
        repeat (4) @(posedge clk_in);
        send(8'h5A, 4'd6, 4'd1, 1'b1);
        repeat (4) @(posedge clk_in);
        send(8'hC3, 4'd8, 4'd1, 1'b0);
        repeat (12) @(posedge clk_in);
        do_reset();
        repeat (4) @(posedge clk_in);

        for (int t = 0; t < 30; t++) begin
            send(8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 2)), 1'b0);
            sel = $urandom_range(0, 5);
            repeat ($urandom_range(0, 40)) @(posedge clk_in);
            if (sel == 0) begin
                do_abort();
            end else if (sel == 1) begin
                do_reset();
            end else if (sel == 2) begin
                send(8'($urandom), 4'($urandom_range(0, 15)), 4'd0, 1'b0);
                wait_drain();
            end else begin
                wait_drain();
            end
        end
        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
